// File: rtl/int_flag_sequencer.sv
// rtl/int_flag_sequencer.sv - RAT CPU interrupt sequencer owning the I flag and Flags shadow controls
//
// Latches rising edges on NUM_SRC interrupt lines into a pending register.
// At an instruction boundary it services the lowest-index eligible source:
// SAVE (shadow C/Z) -> VECT (request + vector) -> ISR -> RESTORE (reload C/Z).
//
// Ports:
//   ISQ_CLK, ISQ_RST_N           clock, asynchronous active-low reset
//   ISQ_IRQ, ISQ_MASK            interrupt lines (rising-edge sensitive), per-source enables
//   ISQ_SEI, ISQ_CLI, ISQ_RETIE  instruction strobes from the control unit
//   ISQ_INSTR_DONE, ISQ_ACK_DONE instruction-boundary pulse, vector-taken handshake
//   ISQ_INT_REQ, ISQ_VECTOR      interrupt request and its vector address
//   ISQ_SRC_ID, ISQ_I_FLAG       source being serviced, global interrupt enable
//   ISQ_IN_ISR, ISQ_PEND         in-service indicator, pending register
//   ISQ_FLG_*                    Flags block shadow save/restore controls
module int_flag_sequencer #(
  parameter int         NUM_SRC  = 4,
  parameter logic [9:0] VEC_BASE = 10'h3F0,
  parameter int         ID_W     = $clog2(NUM_SRC)
) (
  input  logic               ISQ_CLK,
  input  logic               ISQ_RST_N,
  input  logic [NUM_SRC-1:0] ISQ_IRQ,
  input  logic [NUM_SRC-1:0] ISQ_MASK,
  input  logic               ISQ_SEI,
  input  logic               ISQ_CLI,
  input  logic               ISQ_RETIE,
  input  logic               ISQ_INSTR_DONE,
  input  logic               ISQ_ACK_DONE,
  output logic               ISQ_INT_REQ,
  output logic [9:0]         ISQ_VECTOR,
  output logic [ID_W-1:0]    ISQ_SRC_ID,
  output logic               ISQ_I_FLAG,
  output logic               ISQ_IN_ISR,
  output logic [NUM_SRC-1:0] ISQ_PEND,
  output logic               ISQ_FLG_SHAD_LD,
  output logic               ISQ_FLG_LD_SEL,
  output logic               ISQ_FLG_C_LD,
  output logic               ISQ_FLG_Z_LD
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SAVE    = 3'd1,
    S_VECT    = 3'd2,
    S_ISR     = 3'd3,
    S_RESTORE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] irq_prev_q;
  logic               i_q, i_d;
  logic [ID_W-1:0]    src_id_q, src_id_d;
  logic [NUM_SRC-1:0] elig, rise;
  logic [ID_W-1:0]    winner;

  // Registered Moore outputs: loaded from the next state so they line up
  // exactly with state_q and add no latency.
  logic       int_req_q, in_isr_q, shad_ld_q, restore_q;
  logic [9:0] vector_q;

  assign elig = pend_q & ISQ_MASK;
  assign rise = ISQ_IRQ & ~irq_prev_q;

  // Lowest set index wins; scanning downward lets the lowest index overwrite.
  always_comb begin
    winner = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (elig[k]) winner = ID_W'(k);
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    src_id_d = src_id_q;
    i_d      = i_q;
    if (ISQ_SEI) i_d = 1'b1;
    if (ISQ_CLI) i_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_q && (|elig) && ISQ_INSTR_DONE) begin
          state_d  = S_SAVE;
          src_id_d = winner;
        end
      end
      S_SAVE: begin
        i_d     = 1'b0;
        pend_d  = pend_q & ~(NUM_SRC'(1) << src_id_q);
        state_d = S_VECT;
      end
      S_VECT:    if (ISQ_ACK_DONE) state_d = S_ISR;
      S_ISR:     if (ISQ_RETIE) state_d = S_RESTORE;
      S_RESTORE: begin
        i_d     = 1'b1;
        state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
    // Applied last so a fresh edge in the SAVE cycle survives the clear.
    pend_d = pend_d | rise;
  end

  always_ff @(posedge ISQ_CLK or negedge ISQ_RST_N) begin
    if (!ISQ_RST_N) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      irq_prev_q <= '0;
      i_q        <= 1'b0;
      src_id_q   <= '0;
      int_req_q  <= 1'b0;
      in_isr_q   <= 1'b0;
      shad_ld_q  <= 1'b0;
      restore_q  <= 1'b0;
      vector_q   <= VEC_BASE;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      irq_prev_q <= ISQ_IRQ;
      i_q        <= i_d;
      src_id_q   <= src_id_d;
      int_req_q  <= (state_d == S_VECT);
      in_isr_q   <= (state_d != S_IDLE);
      shad_ld_q  <= (state_d == S_SAVE);
      restore_q  <= (state_d == S_RESTORE);
      vector_q   <= VEC_BASE + {{(10 - ID_W){1'b0}}, src_id_d};
    end
  end

  assign ISQ_INT_REQ     = int_req_q;
  assign ISQ_VECTOR      = vector_q;
  assign ISQ_SRC_ID      = src_id_q;
  assign ISQ_I_FLAG      = i_q;
  assign ISQ_IN_ISR      = in_isr_q;
  assign ISQ_PEND        = pend_q;
  assign ISQ_FLG_SHAD_LD = shad_ld_q;
  assign ISQ_FLG_LD_SEL  = restore_q;
  assign ISQ_FLG_C_LD    = restore_q;
  assign ISQ_FLG_Z_LD    = restore_q;

endmodule
